// File: rtl/stopwatch_counter.sv
// MM:SS time-keeping core for the lab3 stopwatch: counts from a 1 Hz tick, pauses/clears,
// and advances the selected field from a 2 Hz tick while in adjust mode.
module stopwatch_counter #(
  parameter int unsigned MAX_MIN = 59,
  parameter int unsigned MAX_SEC = 59,
  parameter int unsigned W       = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick_1hz,
  input  logic         tick_2hz,
  input  logic         adj,
  input  logic         sel,
  input  logic         pause_pulse,
  input  logic         clear_pulse,
  output logic [W-1:0] minutes,
  output logic [W-1:0] seconds,
  output logic         running,
  output logic         blink_min,
  output logic         blink_sec
);

  typedef enum logic [1:0] {StRun, StPaused, StAdjust} state_e;

  localparam logic [W-1:0] MaxMin = W'(MAX_MIN);
  localparam logic [W-1:0] MaxSec = W'(MAX_SEC);

  logic [W-1:0] min_q, min_d;
  logic [W-1:0] sec_q, sec_d;
  logic         run_q, run_d;
  state_e       state;

  // >= rather than == keeps any out-of-range value from counting past the limit.
  function automatic logic [W-1:0] wrap_inc(input logic [W-1:0] v, input logic [W-1:0] max);
    return (v >= max) ? '0 : v + 1'b1;
  endfunction

  // adj is a level, so the mode is derived each cycle rather than stored.
  always_comb begin
    if (adj) begin
      state = StAdjust;
    end else if (run_q) begin
      state = StRun;
    end else begin
      state = StPaused;
    end
  end

  always_comb begin
    min_d = min_q;
    sec_d = sec_q;
    run_d = run_q ^ pause_pulse;
    if (clear_pulse) begin
      min_d = '0;
      sec_d = '0;
    end else begin
      unique case (state)
        StAdjust: begin
          if (tick_2hz) begin
            if (sel) begin
              sec_d = wrap_inc(sec_q, MaxSec);
            end else begin
              min_d = wrap_inc(min_q, MaxMin);
            end
          end
        end
        StRun: begin
          if (tick_1hz) begin
            sec_d = wrap_inc(sec_q, MaxSec);
            if (sec_q >= MaxSec) begin
              min_d = wrap_inc(min_q, MaxMin);
            end
          end
        end
        StPaused: begin
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '0;
      sec_q <= '0;
      run_q <= 1'b1;
    end else begin
      min_q <= min_d;
      sec_q <= sec_d;
      run_q <= run_d;
    end
  end

  assign minutes   = min_q;
  assign seconds   = sec_q;
  assign running   = (state == StRun);
  assign blink_min = adj & ~sel;
  assign blink_sec = adj & sel;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter: directed table, test-plan sequences and
// randomized stimulus against a total-seconds reference model.
module tb_stopwatch_counter;

  localparam int MaxMin = 59;
  localparam int MaxSec = 59;
  localparam int W      = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tick_1hz, tick_2hz, adj, sel, pause_pulse, clear_pulse;
  logic [W-1:0] minutes, seconds;
  logic         running, blink_min, blink_sec;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_min, m_sec;
  bit m_run;

  typedef struct {
    logic a, s, t1, t2, p, c;
    int   exp_min, exp_sec;
    logic exp_running;
  } vec_t;

  vec_t vecs[13];

  stopwatch_counter #(
    .MAX_MIN(MaxMin),
    .MAX_SEC(MaxSec),
    .W      (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_1hz   (tick_1hz),
    .tick_2hz   (tick_2hz),
    .adj        (adj),
    .sel        (sel),
    .pause_pulse(pause_pulse),
    .clear_pulse(clear_pulse),
    .minutes    (minutes),
    .seconds    (seconds),
    .running    (running),
    .blink_min  (blink_min),
    .blink_sec  (blink_sec)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("minutes", int'(minutes), m_min);
    check("seconds", int'(seconds), m_sec);
    check("running", int'(running), int'(m_run && !adj));
    check("blink_min", int'(blink_min), int'(adj && !sel));
    check("blink_sec", int'(blink_sec), int'(adj && sel));
  endtask

  task automatic expect_time(input string name, input int mm, input int ss, input int run);
    check({name, ".min"}, int'(minutes), mm);
    check({name, ".sec"}, int'(seconds), ss);
    check({name, ".run"}, int'(running), run);
  endtask

  task automatic model_reset();
    m_min = 0;
    m_sec = 0;
    m_run = 1'b1;
  endtask

  // Model: running time is one total-seconds count modulo an hour.
  task automatic model_step(input bit a, input bit s, input bit t1, input bit t2,
                            input bit p, input bit c);
    int total;
    if (c) begin
      m_min = 0;
      m_sec = 0;
    end else if (a) begin
      if (t2 && s) m_sec = (m_sec + 1) % (MaxSec + 1);
      if (t2 && !s) m_min = (m_min + 1) % (MaxMin + 1);
    end else if (m_run && t1) begin
      total = m_min * (MaxSec + 1) + m_sec + 1;
      total = total % ((MaxMin + 1) * (MaxSec + 1));
      m_min = total / (MaxSec + 1);
      m_sec = total % (MaxSec + 1);
    end
    if (p) m_run = !m_run;
  endtask

  // Drive one cycle of inputs, clock it, then compare against the model.
  task automatic step(input bit a, input bit s, input bit t1, input bit t2,
                      input bit p, input bit c);
    adj         = a;
    sel         = s;
    tick_1hz    = t1;
    tick_2hz    = t2;
    pause_pulse = p;
    clear_pulse = c;
    @(posedge clk);
    #1;
    model_step(a, s, t1, t2, p, c);
    tick_1hz    = 1'b0;
    tick_2hz    = 1'b0;
    pause_pulse = 1'b0;
    clear_pulse = 1'b0;
    check_model();
  endtask

  task automatic adjust_to(input int mm, input int ss);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < mm; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < ss; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    //          a     s     t1    t2    p     c     mm  ss  run
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 2, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 2, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 2, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 3, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 3, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 4, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1, 1'b1};

    rst_n       = 1'b0;
    tick_1hz    = 1'b0;
    tick_2hz    = 1'b0;
    adj         = 1'b0;
    sel         = 1'b0;
    pause_pulse = 1'b0;
    clear_pulse = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    expect_time("reset", 0, 0, 1);
    check_model();
    #2 rst_n = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
      step(vecs[i].a, vecs[i].s, vecs[i].t1, vecs[i].t2, vecs[i].p, vecs[i].c);
      expect_time($sformatf("vec%0d", i), vecs[i].exp_min, vecs[i].exp_sec,
                  int'(vecs[i].exp_running));
    end

    // 61 seconds from 00:00
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 61; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_time("count61", 1, 1, 1);

    // Preload 59:58 then roll over the hour
    adjust_to(59, 58);
    expect_time("preload", 59, 58, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_time("to5959", 59, 59, 1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_time("wrap0000", 0, 0, 1);

    // Adjust wrap on seconds: no carry into minutes, 1 Hz ignored
    adjust_to(3, 59);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_time("adjwrap", 3, 0, 0);
    check("adjwrap.blink_sec", int'(blink_sec), 1);
    check("adjwrap.blink_min", int'(blink_min), 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_time("adj1hz", 3, 0, 0);

    // Pause / resume
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_time("paused", 0, 5, 0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_time("paused10", 0, 5, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_time("resumed", 0, 6, 1);

    // Clear beats a coincident tick, run flag untouched
    adjust_to(3, 20);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_time("clr_run", 0, 0, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    adjust_to(3, 20);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_time("clr_pause", 0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset between edges at 12:34
    adjust_to(12, 34);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_time("at1234", 12, 34, 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    expect_time("async_rst", 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_time("post_rst", 0, 1, 1);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 15) == 0) ? !adj : adj,
           ($urandom_range(0, 7) == 0) ? !sel : sel,
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 39) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
